// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants for the byte-addressable RAM
package ram_pkg;

    localparam int LANE_WIDTH = 8;

    localparam logic [0:0] ST_SCRUB = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/byte_merge.sv
// rtl/byte_merge.sv - combinational per-byte merge of an old and a new word
module byte_merge
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]            old_word,
    input  logic [DATA_WIDTH-1:0]            new_word,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] mask,
    output logic [DATA_WIDTH-1:0]            merged
);

    for (genvar k = 0; k < DATA_WIDTH / LANE_WIDTH; k++) begin : g_lane
        assign merged[k*LANE_WIDTH +: LANE_WIDTH] = mask[k] ? new_word[k*LANE_WIDTH +: LANE_WIDTH]
                                                            : old_word[k*LANE_WIDTH +: LANE_WIDTH];
    end

endmodule

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - dual-port (instruction read / data read-write) byte-maskable RAM
// with a power-on scrub that zeroes every word before accesses are accepted.
module byte_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                            clock,
    input  logic                            reset,
    output logic                            ready,
    input  logic [ADDR_WIDTH-1:0]           i_address,
    output logic [DATA_WIDTH-1:0]           i_read_data,
    input  logic                            wEn,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] d_byte_en,
    input  logic [ADDR_WIDTH-1:0]           d_address,
    input  logic [DATA_WIDTH-1:0]           d_write_data,
    output logic [DATA_WIDTH-1:0]           d_read_data,
    output logic                            d_addr_err
);

    localparam int LANES       = DATA_WIDTH / LANE_WIDTH;
    localparam int OFFSET_BITS = $clog2(LANES);
    localparam int IDX_W       = ADDR_WIDTH - OFFSET_BITS;
    localparam int DEPTH       = 1 << DEPTH_LOG2;

    logic [0:0]            state;
    logic [DEPTH_LOG2-1:0] scrub_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      i_idx;
    logic [IDX_W-1:0]      d_idx;
    logic [DEPTH_LOG2-1:0] i_slot;
    logic [DEPTH_LOG2-1:0] d_slot;
    logic                  i_in_range;
    logic                  d_in_range;
    logic                  running;
    logic                  d_write;
    logic                  i_fwd;
    logic [LANES-1:0]      merge_mask;
    logic [DATA_WIDTH-1:0] d_old;
    logic [DATA_WIDTH-1:0] d_merged;
    logic                  addr_offset_unused;

    assign i_idx  = i_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign d_idx  = d_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign i_slot = i_idx[DEPTH_LOG2-1:0];
    assign d_slot = d_idx[DEPTH_LOG2-1:0];

    // Byte offsets never select anything: misaligned accesses hit the containing word.
    assign addr_offset_unused = ^{i_address[OFFSET_BITS-1:0], d_address[OFFSET_BITS-1:0]};

    if (IDX_W > DEPTH_LOG2) begin : g_range
        assign i_in_range = (i_idx[IDX_W-1:DEPTH_LOG2] == '0);
        assign d_in_range = (d_idx[IDX_W-1:DEPTH_LOG2] == '0);
    end else begin : g_full
        assign i_in_range = 1'b1;
        assign d_in_range = 1'b1;
    end

    assign running    = (state == ST_RUN);
    assign ready      = running;
    assign merge_mask = wEn ? d_byte_en : '0;
    assign d_old      = mem[d_slot];
    assign d_write    = running && wEn && d_in_range && (|d_byte_en);
    assign i_fwd      = d_write && (i_idx == d_idx);

    // One merge serves the array write and both write-first read returns.
    byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .old_word (d_old),
        .new_word (d_write_data),
        .mask     (merge_mask),
        .merged   (d_merged)
    );

    always_ff @(posedge clock) begin
        if (state == ST_SCRUB) begin
            mem[scrub_cnt] <= '0;
        end else if (d_write) begin
            mem[d_slot] <= d_merged;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_SCRUB;
            scrub_cnt   <= '0;
            i_read_data <= '0;
            d_read_data <= '0;
            d_addr_err  <= 1'b0;
        end else if (state == ST_SCRUB) begin
            scrub_cnt   <= scrub_cnt + 1'b1;
            i_read_data <= '0;
            d_read_data <= '0;
            d_addr_err  <= 1'b0;
            if (scrub_cnt == '1) begin
                state <= ST_RUN;
            end
        end else begin
            d_addr_err  <= ~d_in_range;
            d_read_data <= d_in_range ? d_merged : '0;
            if (!i_in_range) begin
                i_read_data <= '0;
            end else if (i_fwd) begin
                i_read_data <= d_merged;
            end else begin
                i_read_data <= mem[i_slot];
            end
        end
    end

endmodule

// File: tb/tb_byte_ram.sv
// tb/tb_byte_ram.sv - self-checking bench for byte_ram with a word-array reference model
module tb_byte_ram;

    localparam int DW     = 32;
    localparam int AW     = 16;
    localparam int DL2    = 4;
    localparam int DEPTH  = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ready;
    logic [AW-1:0] i_address = '0;
    logic [DW-1:0] i_read_data;
    logic          wEn = 1'b0;
    logic [3:0]    d_byte_en = '0;
    logic [AW-1:0] d_address = '0;
    logic [DW-1:0] d_write_data = '0;
    logic [DW-1:0] d_read_data;
    logic          d_addr_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] ref_mem [DEPTH];

    byte_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ready        (ready),
        .i_address    (i_address),
        .i_read_data  (i_read_data),
        .wEn          (wEn),
        .d_byte_en    (d_byte_en),
        .d_address    (d_address),
        .d_write_data (d_write_data),
        .d_read_data  (d_read_data),
        .d_addr_err   (d_addr_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_port(input logic we, input logic [3:0] be, input logic [AW-1:0] da,
                            input logic [31:0] wd, input logic [AW-1:0] ia);
        wEn = we; d_byte_en = be; d_address = da; d_write_data = wd; i_address = ia;
    endtask

    // Reference step: apply the write to the word array, then read both ports.
    task automatic model_step(output logic [31:0] exp_d, output logic [31:0] exp_i, output logic exp_err);
        int di;
        int ii;
        di = int'(d_address) / 4;
        ii = int'(i_address) / 4;
        if (di < DEPTH && wEn) begin
            for (int k = 0; k < 4; k++)
                if (d_byte_en[k]) ref_mem[di][8*k +: 8] = d_write_data[8*k +: 8];
        end
        exp_d   = (di < DEPTH) ? ref_mem[di] : 32'h0;
        exp_i   = (ii < DEPTH) ? ref_mem[ii] : 32'h0;
        exp_err = (di >= DEPTH);
    endtask

    task automatic run_check(input string tag);
        logic [31:0] ed;
        logic [31:0] ei;
        logic        ee;
        model_step(ed, ei, ee);
        tick();
        check({tag, "_d"}, d_read_data, ed);
        check({tag, "_i"}, i_read_data, ei);
        check({tag, "_err"}, {31'b0, d_addr_err}, {31'b0, ee});
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (!ready && cnt < 40) begin
            tick();
            cnt++;
            if (cnt == 8) check({tag, "_scrub_d0"}, d_read_data, 32'h0);
            if (cnt == 8) check({tag, "_scrub_i0"}, i_read_data, 32'h0);
        end
        check({tag, "_ready_latency"}, cnt, 16);
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = 32'h0;
    endtask

    initial begin
        logic [31:0] ed;
        logic [31:0] ei;
        logic        ee;

        #1;
        check("rst_ready", {31'b0, ready}, 32'h0);
        check("rst_d", d_read_data, 32'h0);
        check("rst_i", i_read_data, 32'h0);
        check("rst_err", {31'b0, d_addr_err}, 32'h0);
        tick();
        tick();

        // Scrub with a write attempt held on the data port.
        set_port(1'b1, 4'hF, 16'd4, 32'hFFFF_FFFF, 16'd4);
        reset = 1'b0;
        wait_ready("scrub1");
        set_port(1'b0, 4'h0, 16'd0, 32'h0, 16'd0);

        for (int w = 0; w < DEPTH; w++) begin
            set_port(1'b0, 4'h0, AW'(w * 4), 32'h0, AW'(((w + 5) % DEPTH) * 4));
            run_check("zero_read");
        end
        check("scrub_gate_w4", ref_mem[1], 32'h0);

        set_port(1'b1, 4'hF, 16'd4, 32'hAABB_CCDD, 16'd0);
        run_check("merge_full");
        set_port(1'b1, 4'b0101, 16'd4, 32'h1122_3344, 16'd4);
        tick();
        check("merge_wf_d", d_read_data, 32'hAA22_CC44);
        check("merge_wf_i", i_read_data, 32'hAA22_CC44);
        ref_mem[1] = 32'hAA22_CC44;
        set_port(1'b0, 4'h0, 16'd5, 32'h0, 16'd7);
        run_check("merge_misaligned");

        set_port(1'b1, 4'hF, 16'd8, 32'h0000_0008, 16'd8);
        tick();
        check("fwd_d", d_read_data, 32'h0000_0008);
        check("fwd_i", i_read_data, 32'h0000_0008);
        ref_mem[2] = 32'h0000_0008;

        set_port(1'b1, 4'hF, 16'd64, 32'hDEAD_BEEF, 16'd64);
        tick();
        check("oor_err", {31'b0, d_addr_err}, 32'h1);
        check("oor_d", d_read_data, 32'h0);
        check("oor_i", i_read_data, 32'h0);
        set_port(1'b0, 4'h0, 16'd0, 32'h0, 16'd0);
        tick();
        check("oor_err_drop", {31'b0, d_addr_err}, 32'h0);
        check("oor_word0", d_read_data, 32'h0);

        set_port(1'b1, 4'h0, 16'd8, 32'h5555_5555, 16'd0);
        run_check("mask_zero");

        for (int n = 0; n < 300; n++) begin
            set_port(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     AW'($urandom_range(0, 95)), $urandom, AW'($urandom_range(0, 95)));
            if (n % 7 == 0) i_address = d_address;
            model_step(ed, ei, ee);
            tick();
            check("rand_d", d_read_data, ed);
            check("rand_i", i_read_data, ei);
            check("rand_err", {31'b0, d_addr_err}, {31'b0, ee});
        end

        // Reset in RUN forces outputs immediately, then a reset mid-scrub restarts it.
        set_port(1'b0, 4'h0, 16'd64, 32'h0, 16'd0);
        tick();
        reset = 1'b1;
        #1;
        check("run_rst_ready", {31'b0, ready}, 32'h0);
        check("run_rst_err", {31'b0, d_addr_err}, 32'h0);
        check("run_rst_d", d_read_data, 32'h0);
        tick();
        set_port(1'b0, 4'h0, 16'd0, 32'h0, 16'd0);
        reset = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        check("mid_scrub_ready", {31'b0, ready}, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        check("mid_rst_ready", {31'b0, ready}, 32'h0);
        set_port(1'b1, 4'hF, 16'd12, 32'hCAFE_F00D, 16'd12);
        reset = 1'b0;
        wait_ready("scrub2");
        for (int w = 0; w < DEPTH; w++) begin
            set_port(1'b0, 4'h0, AW'(w * 4), 32'h0, AW'(w * 4));
            run_check("rescrub_read");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_ram.md
BYTE_RAM -- requirements
Module: byte_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values are multiples of 8, minimum 16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte-address width of both ports.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10, log2 of stored word count; the word count is DEPTH = 2^DEPTH_LOG2.
REQ-004 SHALL have port clock, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port ready, output, 1 bit, high when the memory scrub is complete and accesses are accepted.
REQ-007 SHALL have port i_address, input, ADDR_WIDTH bits, instruction-port byte address.
REQ-008 SHALL have port i_read_data, output, DATA_WIDTH bits, instruction-port registered read data.
REQ-009 SHALL have port wEn, input, 1 bit, data-port write enable.
REQ-010 SHALL have port d_byte_en, input, DATA_WIDTH/8 bits, per-byte write mask; bit k covers bits [8k+7:8k].
REQ-011 SHALL have port d_address, input, ADDR_WIDTH bits, data-port byte address.
REQ-012 SHALL have port d_write_data, input, DATA_WIDTH bits, data-port write data.
REQ-013 SHALL have port d_read_data, output, DATA_WIDTH bits, data-port registered read data.
REQ-014 SHALL have port d_addr_err, output, 1 bit, one-cycle pulse flagging an out-of-range data-port access.

Function
REQ-015 SHALL derive the word index from an address as address[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)], ignoring the low byte-offset bits; misaligned addresses therefore access the containing word.
REQ-016 SHALL treat a word index >= DEPTH as out of range.
REQ-017 SHALL have a two-state FSM, SCRUB then RUN; SCRUB writes zero to word 0,1,...,DEPTH-1, one word per cycle, then moves to RUN; RUN is terminal until reset.
REQ-018 SHALL deassert ready throughout SCRUB, and assert ready in the first cycle after word DEPTH-1 is written, i.e. DEPTH cycles after reset release.
REQ-019 SHALL, in SCRUB, ignore wEn and drive both read-data outputs to 0.
REQ-020 SHALL, in RUN with wEn=1 and an in-range word index, update exactly the bytes whose d_byte_en bit is 1, at the rising edge.
REQ-021 SHALL have a read latency of one cycle on both ports: the output after edge N reflects the address sampled at edge N.
REQ-022 SHALL make the data port write-first: a read of the word written at the same edge returns the merged post-write word.
REQ-023 SHALL forward the merged post-write word to i_read_data when i_address and d_address select the same word at the same write edge.
REQ-024 SHALL, for an out-of-range data-port access in RUN, drop the write, load 0 into d_read_data and pulse d_addr_err for one cycle; this applies to writes and reads alike.
REQ-025 SHALL load 0 into i_read_data for an out-of-range instruction-port read, with no error flag.
REQ-026 SHALL treat wEn=1 with d_byte_en all zero as a read with no memory change.

Reset
REQ-027 SHALL, while reset is high, immediately force ready=0, i_read_data=0, d_read_data=0, d_addr_err=0, the FSM to SCRUB and the scrub counter to 0.
REQ-028 SHALL restart the scrub from word 0 when reset is asserted mid-scrub or in RUN.
REQ-029 SHALL leave memory array contents unaffected by reset itself; clearing occurs only through the scrub.

Structure
REQ-030 SHALL place the FSM state encoding (SCRUB, RUN) and the byte-lane width constant 8 in the shared package ram_pkg.
REQ-031 SHALL keep a single sub-module, byte_merge, a combinational merge of old word, new word and byte mask, reused for the write path and for forwarding.
REQ-032 SHALL hold all other logic, including the FSM, counter, array and output registers, in byte_ram.

Verification
REQ-033 Bench SHALL check scrub: release reset with DEPTH=16 -> ready rises exactly 16 cycles later, and reading all words returns 0.
REQ-034 Bench SHALL check byte merge: write 0xAABBCCDD with all-ones mask to address 4, then 0x11223344 with mask 4'b0101 -> address 4 reads 0xAA22CC44.
REQ-035 Bench SHALL check collision forwarding: write 0x00000008 to address 8 with i_address=8 in the same cycle -> both read ports return 0x00000008 next cycle.
REQ-036 Bench SHALL check the out-of-range path: with DEPTH=16, write to address 64 -> d_addr_err pulses once, d_read_data=0, and word 0 is unchanged.
REQ-037 Bench SHALL check reset mid-scrub: assert reset at scrub cycle 7 -> ready stays 0 and becomes 1 exactly 16 cycles after the second release.
REQ-038 Bench SHALL check write gating during scrub: wEn=1 to address 4 during SCRUB -> address 4 reads 0 after ready.
